// File: rtl/pio_cmd_sequencer.sv
// Register-slave command sequencer: software loads an opcode and strobes START, the block runs
// a req/ack/done handshake with a cycle timeout. Optional irq output via `PIO_CMD_IRQ_EN.
module pio_cmd_sequencer #(
    parameter int OP_W  = 4,
    parameter int TO_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            eng_req,
    output logic [OP_W-1:0] eng_op,
    input  logic            eng_ack,
    input  logic            eng_done,
    output logic            eng_abort
`ifdef PIO_CMD_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [OP_W-1:0]  cmd_q, cmd_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;

    logic wr, busy, start_req, clear_req, start_ok, complete, timeout_fire;
    logic unused_wd;

    assign unused_wd = ^writedata;

    assign wr        = chipselect && !write_n;
    assign busy      = (state_q != IDLE);
    assign start_req = wr && (address == 2'd1) && writedata[0];
    assign clear_req = wr && (address == 2'd1) && writedata[1];
    assign start_ok  = start_req && !busy;
    assign complete  = ((state_q == REQ) && eng_ack && eng_done) || ((state_q == RUN) && eng_done);
    // Completion in the same cycle always wins over an expiring timer.
    assign timeout_fire = busy && (timeout_q != '0) && (timer_q == timeout_q) && !complete;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        op_d      = op_q;
        timeout_d = timeout_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        ovr_d     = ovr_q;

        if (wr && (address == 2'd0) && !busy)
            cmd_d = writedata[OP_W-1:0];
        if (wr && (address == 2'd3))
            timeout_d = writedata[TO_W-1:0];

        if (busy && (timer_q != {TO_W{1'b1}}))
            timer_d = timer_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = REQ;
                    op_d    = cmd_q;
                    timer_d = '0;
                end
            end
            REQ: begin
                if (complete || timeout_fire)
                    state_d = IDLE;
                else if (eng_ack)
                    state_d = RUN;
            end
            RUN: begin
                if (complete || timeout_fire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ordering below makes flag sets win over CLEAR in the same cycle.
        if (clear_req) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            ovr_d  = 1'b0;
        end
        if (start_ok) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (start_req && busy)
            ovr_d = 1'b1;
        if (complete) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
        if (timeout_fire)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            op_q      <= '0;
            timeout_q <= '0;
            timer_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            op_q      <= op_d;
            timeout_q <= timeout_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign eng_req   = (state_q == REQ);
    assign eng_op    = op_q;
    assign eng_abort = timeout_fire;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[OP_W-1:0] = cmd_q;
            2'd2: begin
                readdata[3:0]         = {ovr_q, err_q, done_q, busy};
                readdata[8 +: CNT_W]  = cnt_q;
            end
            2'd3: readdata[TO_W-1:0] = timeout_q;
            default: readdata = '0;
        endcase
    end

`ifdef PIO_CMD_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = done_q | err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Self-checking bench for pio_cmd_sequencer: scoreboarded opcodes and STATUS values per command.
module tb_pio_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        eng_req;
    logic [3:0]  eng_op;
    logic        eng_ack = 1'b0;
    logic        eng_done = 1'b0;
    logic        eng_abort;
`ifdef PIO_CMD_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model_cnt = '0;
    logic [31:0] exp_status_q[$];
    logic [3:0]  exp_op_q[$];

    pio_cmd_sequencer #(.OP_W(4), .TO_W(16), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .eng_req    (eng_req),
        .eng_op     (eng_op),
        .eng_ack    (eng_ack),
        .eng_done   (eng_done),
        .eng_abort  (eng_abort)
`ifdef PIO_CMD_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            n_checks++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_readdata addr=%0d got=%h exp=%h", a, v, 32'h0);
            end
        end
        n_checks++;
        if (eng_req !== 1'b0 || eng_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b abort=%b exp req=0 abort=0", eng_req, eng_abort);
        end
`ifdef PIO_CMD_IRQ_EN
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
`endif
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [31:0] v, es;
        logic [3:0]  eo;
        bus_write(2'd0, 32'h5);
        exp_op_q.push_back(4'h5);
        model_cnt = model_cnt + 8'd1;
        exp_status_q.push_back({16'h0, model_cnt, 8'h02});
        bus_write(2'd1, 32'h1);
        eo = exp_op_q.pop_front();
        n_checks++;
        if (eng_req !== 1'b1 || eng_op !== eo) begin
            n_fail++;
            $display("FAIL basic_start got req=%b op=%h exp req=1 op=%h", eng_req, eng_op, eo);
        end
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'h1) begin
            n_fail++;
            $display("FAIL basic_busy got=%h exp=%h", v, 32'h1);
        end
        tick();
        tick();
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        n_checks++;
        if (eng_req !== 1'b0 || eng_op !== eo) begin
            n_fail++;
            $display("FAIL basic_after_ack got req=%b op=%h exp req=0 op=%h", eng_req, eng_op, eo);
        end
        repeat (4) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        es = exp_status_q.pop_front();
        rd(2'd2, v);
        n_checks++;
        if (v !== es) begin
            n_fail++;
            $display("FAIL basic_status got=%h exp=%h", v, es);
        end
        $display("test_basic: op=%h status=%h", eng_op, v);
    endtask

    task automatic test_timeout();
        logic [31:0] v, es;
        int cyc, abort_at;
        bus_write(2'd3, 32'd10);
        exp_status_q.push_back({16'h0, model_cnt, 8'h04});
        bus_write(2'd1, 32'h1);
        cyc = 1;
        abort_at = 0;
        while (abort_at == 0 && cyc < 40) begin
            if (eng_abort === 1'b1) abort_at = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        n_checks++;
        if (abort_at != 11) begin
            n_fail++;
            $display("FAIL timeout_abort_cycle got=N+%0d exp=N+11", abort_at);
        end
        tick();
        n_checks++;
        if (eng_abort !== 1'b0 || eng_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse_end got abort=%b req=%b exp 0/0", eng_abort, eng_req);
        end
        es = exp_status_q.pop_front();
        rd(2'd2, v);
        n_checks++;
        if (v !== es) begin
            n_fail++;
            $display("FAIL timeout_status got=%h exp=%h", v, es);
        end
        bus_write(2'd1, 32'h2);
        rd(2'd2, v);
        n_checks++;
        if (v !== {16'h0, model_cnt, 8'h00}) begin
            n_fail++;
            $display("FAIL timeout_clear got=%h exp=%h", v, {16'h0, model_cnt, 8'h00});
        end
        rd(2'd3, v);
        n_checks++;
        if (v !== 32'd10) begin
            n_fail++;
            $display("FAIL timeout_readback got=%h exp=%h", v, 32'd10);
        end
        bus_write(2'd3, 32'd0);
        $display("test_timeout: abort at N+%0d", abort_at);
    endtask

    task automatic test_overrun();
        logic [31:0] v, es;
        logic [3:0]  eo;
        bus_write(2'd0, 32'h6);
        exp_op_q.push_back(4'h6);
        bus_write(2'd1, 32'h1);
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        bus_write(2'd0, 32'h3);
        bus_write(2'd1, 32'h1);
        eo = exp_op_q.pop_front();
        n_checks++;
        if (eng_op !== eo) begin
            n_fail++;
            $display("FAIL overrun_op got=%h exp=%h", eng_op, eo);
        end
        rd(2'd0, v);
        n_checks++;
        if (v !== {28'h0, eo}) begin
            n_fail++;
            $display("FAIL overrun_cmd_ignored got=%h exp=%h", v, {28'h0, eo});
        end
        rd(2'd2, v);
        n_checks++;
        if (v !== {16'h0, model_cnt, 8'h09}) begin
            n_fail++;
            $display("FAIL overrun_status_busy got=%h exp=%h", v, {16'h0, model_cnt, 8'h09});
        end
        model_cnt = model_cnt + 8'd1;
        exp_status_q.push_back({16'h0, model_cnt, 8'h0A});
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        es = exp_status_q.pop_front();
        rd(2'd2, v);
        n_checks++;
        if (v !== es) begin
            n_fail++;
            $display("FAIL overrun_status_done got=%h exp=%h", v, es);
        end
        bus_write(2'd1, 32'h2);
        $display("test_overrun: status=%h", v);
    endtask

    task automatic test_same_cycle();
        logic [31:0] v, es;
        logic [3:0]  eo;
        bus_write(2'd0, 32'h9);
        exp_op_q.push_back(4'h9);
        model_cnt = model_cnt + 8'd1;
        exp_status_q.push_back({16'h0, model_cnt, 8'h02});
        bus_write(2'd1, 32'h1);
        eng_ack  = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_ack  = 1'b0;
        eng_done = 1'b0;
        eo = exp_op_q.pop_front();
        es = exp_status_q.pop_front();
        rd(2'd2, v);
        n_checks++;
        if (v !== es || eng_req !== 1'b0 || eng_op !== eo) begin
            n_fail++;
            $display("FAIL same_cycle got status=%h req=%b op=%h exp status=%h req=0 op=%h",
                     v, eng_req, eng_op, es, eo);
        end
        // Stray handshake pulses while idle must not disturb anything.
        eng_ack  = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_ack  = 1'b0;
        eng_done = 1'b0;
        rd(2'd2, v);
        n_checks++;
        if (v !== es || eng_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore got status=%h req=%b exp status=%h req=0", v, eng_req, es);
        end
        $display("test_same_cycle: status=%h", v);
    endtask

    task automatic test_priority();
        logic [31:0] v, es;
        bus_write(2'd3, 32'd2);
        model_cnt = model_cnt + 8'd1;
        exp_status_q.push_back({16'h0, model_cnt, 8'h02});
        bus_write(2'd1, 32'h1);
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        tick();
        // Timer reaches the limit now; done and CLEAR arrive in the same cycle.
        eng_done   = 1'b1;
        address    = 2'd1;
        writedata  = 32'h2;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        n_checks++;
        if (eng_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL priority_no_abort got=%b exp=0", eng_abort);
        end
        tick();
        eng_done   = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        es = exp_status_q.pop_front();
        rd(2'd2, v);
        n_checks++;
        if (v !== es) begin
            n_fail++;
            $display("FAIL priority_status got=%h exp=%h", v, es);
        end
        bus_write(2'd3, 32'd0);
        $display("test_priority: status=%h", v);
    endtask

    task automatic test_wrap();
        logic [31:0] v, es;
        int n;
        n = 256 - int'(model_cnt);
        for (int i = 0; i < n; i++) begin
            model_cnt = model_cnt + 8'd1;
            exp_status_q.push_back({16'h0, model_cnt, 8'h02});
            bus_write(2'd1, 32'h1);
            n_checks++;
            if (eng_req !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_restart iter=%0d got req=%b exp=1", i, eng_req);
            end
            eng_ack  = 1'b1;
            eng_done = 1'b1;
            tick();
            eng_ack  = 1'b0;
            eng_done = 1'b0;
            es = exp_status_q.pop_front();
            rd(2'd2, v);
            n_checks++;
            if (v !== es) begin
                n_fail++;
                $display("FAIL wrap_status iter=%0d got=%h exp=%h", i, v, es);
            end
        end
        n_checks++;
        if (v[15:8] !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_zero got=%h exp=%h", v[15:8], 8'h00);
        end
        $display("test_wrap: %0d commands, final status=%h", n, v);
    endtask

`ifdef PIO_CMD_IRQ_EN
    task automatic test_irq();
        bus_write(2'd1, 32'h1);
        eng_ack  = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_ack  = 1'b0;
        eng_done = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early got=%b exp=0", irq);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_rise got=%b exp=1", irq);
        end
        bus_write(2'd1, 32'h2);
        tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear got=%b exp=0", irq);
        end
        model_cnt = model_cnt + 8'd1;
        $display("test_irq: irq=%b", irq);
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(2'd1, 32'h1);
        eng_ack = 1'b1;
        tick();
        eng_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (eng_req !== 1'b0 || eng_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got req=%b abort=%b exp 0/0", eng_req, eng_abort);
        end
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_status got=%h exp=%h", v, 32'h0);
        end
        rd(2'd0, v);
        n_checks++;
        if (v !== 32'h0 || eng_op !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_cmd got cmd=%h op=%h exp 0/0", v, eng_op);
        end
        tick();
        reset = 1'b0;
        model_cnt = '0;
        tick();
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_overrun();
        test_same_cycle();
        test_priority();
        test_wrap();
`ifdef PIO_CMD_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=completion");
        $fatal(1, "watchdog");
    end

endmodule
